// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the clock, issues a start bit,
// shifts data/parity/stop on device clock falling edges and checks the device ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [2:0] fsm_state
);

   // Handshake: a byte is taken on the rising edge where tx_valid=1 and tx_ready=1;
   // tx_ready is high only in IDLE, so nothing is accepted while a frame is in flight.

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INHIBIT = 3'd1,
      S_START   = 3'd2,
      S_BITS    = 3'd3,
      S_ACK     = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   state_t        state;
   logic          clk_meta, clk_sync;
   logic          dat_meta, dat_sync;
   logic [3:0]    hist;
   logic          fe;
   logic [IW-1:0] inh_cnt;
   logic [TW-1:0] wd_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    data_q;
   logic          parity;
   logic          ack_ok;

   assign fsm_state = state;

   // hist[3] is the oldest sample; one pulse per falling edge after three low samples.
   assign fe = (hist == 4'b1000);

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
         hist     <= 4'b1111;
      end else begin
         clk_meta <= ps2_clk;
         clk_sync <= clk_meta;
         dat_meta <= ps2_dat;
         dat_sync <= dat_meta;
         hist     <= {hist[2:0], clk_sync};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         tx_ready   <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         inh_cnt    <= '0;
         wd_cnt     <= '0;
         bit_cnt    <= '0;
         data_q     <= '0;
         parity     <= 1'b0;
         ack_ok     <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            S_IDLE: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               tx_ready   <= 1'b1;
               busy       <= 1'b0;
               if (tx_valid && tx_ready) begin
                  data_q     <= tx_data;
                  parity     <= ~^tx_data;
                  state      <= S_INHIBIT;
                  ps2_clk_oe <= 1'b1;
                  tx_ready   <= 1'b0;
                  busy       <= 1'b1;
                  inh_cnt    <= '0;
               end
            end
            S_INHIBIT: begin
               if (inh_cnt == INH_LAST) begin
                  state      <= S_START;
                  ps2_dat_oe <= 1'b1;
                  wd_cnt     <= '0;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end
            default: begin
               // Watchdog expiry wins over any edge or line event in the same cycle.
               if (wd_cnt == WD_LAST) begin
                  state      <= S_IDLE;
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  error      <= 1'b1;
                  tx_ready   <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
                  case (state)
                     S_START: begin
                        state      <= S_BITS;
                        ps2_clk_oe <= 1'b0;
                        bit_cnt    <= '0;
                     end
                     S_BITS: begin
                        if (fe) begin
                           bit_cnt <= bit_cnt + 4'd1;
                           if (bit_cnt < 4'd8) begin
                              ps2_dat_oe <= ~data_q[bit_cnt[2:0]];
                           end else if (bit_cnt == 4'd8) begin
                              ps2_dat_oe <= ~parity;
                           end else begin
                              ps2_dat_oe <= 1'b0;
                              state      <= S_ACK;
                           end
                        end
                     end
                     S_ACK: begin
                        if (fe) begin
                           ack_ok <= ~dat_sync;
                           state  <= S_RELEASE;
                        end
                     end
                     S_RELEASE: begin
                        if (clk_sync && dat_sync) begin
                           done     <= ack_ok;
                           error    <= ~ack_ok;
                           state    <= S_IDLE;
                           tx_ready <= 1'b1;
                           busy     <= 1'b0;
                        end
                     end
                     default: state <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames, records the host's
// data drive per edge and checks it, plus the outcome pulse, against a queue.
module tb_ps2_host_tx;

   localparam int INH  = 500;
   localparam int TMO  = 3000;
   localparam int HALF = 12;

   logic       clk = 1'b0;
   logic       reset;
   logic       dev_clk, dev_dat;
   logic       line_clk, line_dat;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, busy, done, error;
   logic [2:0] state_dbg;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int acc_cnt = 0;

   logic [12:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic       ack;
      int         edges;
      logic       tmo;
      logic       exp_done;
      logic       exp_err;
   } vec_t;

   vec_t vecs[8];

   assign line_clk = dev_clk & ~ps2_clk_oe;
   assign line_dat = dev_dat & ~ps2_dat_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (line_clk),
      .ps2_dat    (line_dat),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .fsm_state  (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (done && error) begin
         n_err++;
         $display("FAIL done_error_overlap: both high at cycle %0d, required at most one", cyc);
      end
      if (!reset && tx_valid && tx_ready) acc_cnt++;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 90000 cycles");
      $fatal(1, "global timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected {error, done, oe per bit slot}: slot 0 start, 1..8 data LSB first, 9 parity, 10 stop.
   function automatic logic [12:0] exp_frame(input logic [7:0] d, input logic ok);
      logic [12:0] e;
      e[0] = 1'b1;
      for (int i = 0; i < 8; i++) e[1+i] = ~d[i];
      e[9]  = ^d;
      e[10] = 1'b0;
      e[11] = ok;
      e[12] = ~ok;
      return e;
   endfunction

   // driver tasks
   task automatic request(input logic [7:0] d, input logic ok, input logic push, input logic hold);
      int g;
      tx_data  = d;
      tx_valid = 1'b1;
      g = 0;
      while (!tx_ready && g < 1000) begin
         g++;
         @(negedge clk);
      end
      check("request_ready", tx_ready, 1);
      if (push) exp_q.push_back(exp_frame(d, ok));
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic run_frame(input int edges, input logic ack, input logic tmo, input logic abort);
      int n, guard, t_start, d0, e0;
      logic [12:0] act, exp, mask;
      act   = '0;
      mask  = 13'h1800;
      d0    = done_cnt;
      e0    = err_cnt;
      n     = 0;
      guard = 0;
      while (!(ps2_clk_oe && ps2_dat_oe) && guard < INH + 100) begin
         if (ps2_clk_oe && !ps2_dat_oe) n++;
         guard++;
         @(negedge clk);
      end
      check("inhibit_len", n, INH);
      t_start = cyc;
      act[0]  = ps2_clk_oe & ps2_dat_oe;
      mask[0] = 1'b1;
      @(negedge clk);
      check("start_release", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
      repeat (HALF) @(negedge clk);
      for (int k = 1; k <= edges; k++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (k <= 10) begin
            act[k]  = ps2_dat_oe;
            mask[k] = 1'b1;
         end
         dev_clk = 1'b1;
         if (k == 10) dev_dat = ack;
         if (k == 11) dev_dat = 1'b1;
         else repeat (HALF) @(negedge clk);
      end
      if (abort) return;
      guard = 0;
      while (!(done || error) && guard < TMO + 500) begin
         guard++;
         @(negedge clk);
      end
      check("outcome_seen", done | error, 1);
      act[11] = done;
      act[12] = error;
      check("end_idle", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
      if (tmo) check("timeout_at", cyc - t_start, TMO);
      check("exp_q_size", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         check("frame", act & mask, exp & mask);
      end
      @(negedge clk);
      check("one_outcome", (done_cnt - d0) + (err_cnt - e0), 1);
   endtask

   initial begin
      int dr0, er0, a0;
      dev_clk  = 1'b1;
      dev_dat  = 1'b1;
      reset    = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'hAB;

      vecs[0] = '{8'hED, 1'b0, 11, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h00, 1'b0, 11, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'h01, 1'b0, 11, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 11, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'hA5, 1'b0, 11, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8'h55, 1'b0, 4,  1'b1, 1'b0, 1'b1};
      vecs[6] = '{8'($urandom_range(0, 255)), 1'b0, 11, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{8'($urandom_range(0, 255)), 1'b0, 11, 1'b0, 1'b1, 1'b0};

      // reset state, with a request held during reset
      repeat (3) @(negedge clk);
      check("reset_outputs", {ps2_clk_oe, ps2_dat_oe, tx_ready, busy, done, error}, 6'b001000);
      reset    = 1'b0;
      tx_valid = 1'b0;
      @(negedge clk);
      check("no_accept_in_reset", {busy, ps2_clk_oe}, 2'b00);
      repeat (4) @(negedge clk);

      // table-driven frames
      for (int v = 0; v < 8; v++) begin
         request(vecs[v].data, vecs[v].exp_done, 1'b1, 1'b0);
         run_frame(vecs[v].edges, vecs[v].ack, vecs[v].tmo, 1'b0);
         repeat (5) @(negedge clk);
      end

      // reset after the fifth falling edge of a frame
      request(8'h3C, 1'b1, 1'b0, 1'b0);
      run_frame(5, 1'b0, 1'b0, 1'b1);
      dr0   = done_cnt;
      er0   = err_cnt;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midframe_reset", {ps2_clk_oe, ps2_dat_oe, busy, tx_ready, done, error}, 6'b000100);
      repeat (20) @(negedge clk);
      check("midframe_no_pulse", (done_cnt - dr0) + (err_cnt - er0), 0);
      request(8'hF4, 1'b1, 1'b1, 1'b0);
      run_frame(11, 1'b0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);

      // tx_valid held high with changing tx_data during the frame
      a0 = acc_cnt;
      request(8'h12, 1'b1, 1'b1, 1'b1);
      fork
         begin
            run_frame(11, 1'b0, 1'b0, 1'b0);
         end
         begin : churner
            int g;
            g = 0;
            while (g < 20000) begin
               @(negedge clk);
               g++;
               if (done || error) begin
                  tx_data = 8'h34;
                  break;
               end
               tx_data = 8'($urandom_range(0, 255));
            end
         end
      join
      tx_valid = 1'b0;
      exp_q.push_back(exp_frame(8'h34, 1'b1));
      check("hold_accepts", acc_cnt - a0, 2);
      check("hold_busy", busy, 1);
      run_frame(11, 1'b0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
